// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: tree pseudo-LRU, flush, AXI INCR line refill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.

module icache_nway #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    output logic              instr_valid,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    input  logic              rlast,
`ifdef ICACHE_STATS_EN
    output logic              rready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`else
    output logic              rready
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned LVLS   = $clog2(WAYS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? LVLS : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {StIdle, StLookup, StMissAr, StMissR, StResp} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WAY_W-1:0]   victim_q;
    logic [OFF_W-1:0]   beat_q;
    logic               flush_pend_q;
    logic [WAYS-1:0]    valid_q  [SETS];
    logic [PLRU_W-1:0]  plru_q   [SETS];
    logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
    logic [31:0]        data_mem [SETS][WAYS][LINE_WORDS];

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   victim;
    logic               r_beat;
    logic               unused_addr;

    assign off         = addr_q[2 +: OFF_W];
    assign idx         = addr_q[2 + OFF_W +: IDX_W];
    assign tag         = addr_q[ADDR_W-1 -: TAG_W];
    assign unused_addr = ^addr_q[1:0];
    assign arlen       = 8'(LINE_WORDS - 1);
    assign r_beat      = (state_q == StMissR) && rvalid && rready && !rst;

    // Each node on the path is pointed away from the accessed way (1 = victim on the right).
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] t;
        logic [WAY_W-1:0]  w;
        logic              d;
        int unsigned       n;
        t = bits;
        w = way;
        n = 0;
        for (int l = 0; l < LVLS; l++) begin
            d    = w[WAY_W-1];
            w    = w << 1;
            t[n] = ~d;
            n    = 2 * n + (d ? 2 : 1);
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] v;
        logic             d;
        int unsigned      n;
        v = '0;
        n = 0;
        for (int l = 0; l < LVLS; l++) begin
            d = bits[n];
            v = (v << 1) | WAY_W'(d);
            n = 2 * n + (d ? 2 : 1);
        end
        return v;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; PLRU only decides once the set is full.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[idx]);
    end

    always_ff @(posedge clk) begin
        if (r_beat) begin
            data_mem[idx][victim_q][beat_q] <= rdata;
        end
        if (r_beat && rlast) begin
            tag_mem[idx][victim_q] <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            instr_valid  <= 1'b0;
            instr_data   <= '0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (flush && (state_q != StIdle)) begin
                flush_pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                    end else if (pc_valid) begin
                        addr_q  <= pc_addr;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                        instr_data  <= data_mem[idx][hit_way][off];
                        instr_valid <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        victim_q <= victim;
                        beat_q   <= '0;
                        araddr   <= {addr_q[ADDR_W-1:2+OFF_W], (OFF_W + 2)'(0)};
                        arvalid  <= 1'b1;
                        state_q  <= StMissAr;
                    end
                end
                StMissAr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StMissR;
                    end
                end
                StMissR: begin
                    if (rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        // Forward the requested word as it streams past.
                        if (beat_q == off) begin
                            instr_data <= rdata;
                        end
                        if (rlast) begin
                            rready                <= 1'b0;
                            valid_q[idx][victim_q] <= 1'b1;
                            plru_q[idx]           <= plru_touch(plru_q[idx], victim_q);
                            instr_valid           <= 1'b1;
                            state_q               <= StResp;
                        end
                    end
                end
                StResp: begin
                    instr_valid <= 1'b0;
                    state_q     <= StIdle;
                    if (flush || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == StLookup) begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!hit && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (4 ways, 64 sets, 32-word lines) with an AXI read slave
// whose data is the beat byte address.

module tb_icache_nway;

    localparam int unsigned LW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    icache_nway #(
        .ADDR_W    (32),
        .WAYS      (4),
        .SETS      (64),
        .LINE_WORDS(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_valid   (pc_valid),
        .pc_addr    (pc_addr),
        .flush      (flush),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .araddr     (araddr),
        .arlen      (arlen),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rlast      (rlast),
`ifdef ICACHE_STATS_EN
        .rready     (rready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
`else
        .rready     (rready)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ar_exp_q[$];
    int          ar_count = 0;
    bit          burst = 1'b0;
    bit          acc = 1'b0;
    int          beat = 0;
    logic [31:0] base = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // Scoreboard: every response is compared against the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && instr_valid) begin
            if (exp_q.size() == 0) fail("unexpected instr_valid");
            else check("instr_data", instr_data, exp_q.pop_front());
        end
    end

    // AXI read slave with random AR and R stalls.
    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                burst = 1'b0; acc = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            end else begin
                if (!burst) begin
                    arready = 1'b0;
                    if (arvalid) begin
                        arready = ($urandom_range(0, 2) != 0);
                        if (arready) begin
                            ar_count++;
                            if (ar_exp_q.size() == 0) fail("unexpected AR");
                            else check("araddr", araddr, ar_exp_q.pop_front());
                            check("arlen", {24'd0, arlen}, LW - 1);
                            burst = 1'b1; beat = 0; base = araddr; acc = 1'b0;
                        end
                    end
                end else begin
                    arready = 1'b0;
                end
                if (burst) begin
                    if (acc) beat++;
                    if (beat == LW) begin
                        burst = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                    end else begin
                        rvalid = ($urandom_range(0, 3) != 0);
                        rdata  = base + 32'(4 * beat);
                        rlast  = (beat == LW - 1);
                    end
                    acc = rvalid && rready;
                end
            end
        end
    end

    // Called at a negedge with the cache idle.
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input bit with_flush,
                         input bit flush_mid, input string name);
        int n0;
        int cyc;
        bit flushed;
        exp_q.push_back({a[31:2], 2'b00});
        if (exp_miss) ar_exp_q.push_back({a[31:7], 7'd0});
        n0       = ar_count;
        pc_addr  = a;
        pc_valid = 1'b1;
        flush    = with_flush;
        cyc      = 0;
        flushed  = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            flush = 1'b0;
            if (flush_mid && !flushed && rready) begin
                flush   = 1'b1;
                flushed = 1'b1;
            end
        end while (!instr_valid && cyc < 500);
        pc_valid = 1'b0;
        check({name, " response seen"}, 32'(instr_valid), 32'd1);
        check({name, " AR count"}, 32'(ar_count - n0), 32'(exp_miss));
        if (!exp_miss) check({name, " hit latency"}, 32'(cyc), 32'd2);
        @(negedge clk);
        check({name, " pulse width"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " instr_valid"}, 32'(instr_valid), 32'd0);
        check({name, " arvalid"}, 32'(arvalid), 32'd0);
        check({name, " rready"}, 32'(rready), 32'd0);
        check({name, " instr_data"}, instr_data, 32'd0);
        check({name, " araddr"}, araddr, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          miss;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int n;
        vecs[0]  = '{32'h0000_0088, 1'b1};  // cold miss, way 0
        vecs[1]  = '{32'h0000_0088, 1'b0};
        vecs[2]  = '{32'h0000_2088, 1'b1};  // way 1
        vecs[3]  = '{32'h0000_4088, 1'b1};  // way 2
        vecs[4]  = '{32'h0000_6088, 1'b1};  // way 3
        vecs[5]  = '{32'h0000_0088, 1'b0};
        vecs[6]  = '{32'h0000_8088, 1'b1};  // evicts way 2
        vecs[7]  = '{32'h0000_4088, 1'b1};  // evicts way 1
        vecs[8]  = '{32'h0000_0088, 1'b0};
        vecs[9]  = '{32'h0000_6088, 1'b0};
        vecs[10] = '{32'h0000_2088, 1'b1};
        vecs[11] = '{32'h0000_00FC, 1'b0};
        vecs[12] = '{32'h0000_0080, 1'b0};
        vecs[13] = '{32'h0000_1000, 1'b1};
        vecs[14] = '{32'h0000_1004, 1'b0};

        rst = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            fetch(vecs[i].addr, vecs[i].miss, 1'b0, 1'b0, $sformatf("vec%0d", i));
`ifdef ICACHE_STATS_EN
            if (i == 1) begin
                check("hit_count", hit_count, 32'd1);
                check("miss_count", miss_count, 32'd1);
            end
`endif
        end

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        fetch(32'h0000_6088, 1'b1, 1'b0, 1'b0, "after flush");
        fetch(32'h0000_0088, 1'b1, 1'b0, 1'b0, "refill 0x88");
        fetch(32'h0000_0088, 1'b1, 1'b1, 1'b0, "flush with pc_valid");
        fetch(32'h0000_2088, 1'b1, 1'b0, 1'b1, "flush in refill");
        fetch(32'h0000_2088, 1'b1, 1'b0, 1'b0, "line after pending flush");
        fetch(32'h0000_0088, 1'b1, 1'b0, 1'b0, "other line after pending flush");
        fetch(32'h0000_0088, 1'b0, 1'b0, 1'b0, "hit after refill");

        ar_exp_q.push_back(32'h0000_0180);
        pc_addr  = 32'h0000_0188;
        pc_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rready && beat >= 4) && n < 300);
        check("mid-burst reached", 32'(rready), 32'd1);
        rst      = 1'b1;
        pc_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-burst reset");
`ifdef ICACHE_STATS_EN
        check("hit_count after rst", hit_count, 32'd0);
        check("miss_count after rst", miss_count, 32'd0);
`endif
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        fetch(32'h0000_0088, 1'b1, 1'b0, 1'b0, "post-reset 0x88");
        fetch(32'h0000_0188, 1'b1, 1'b0, 1'b0, "post-reset 0x188");
        fetch(32'h0000_0188, 1'b0, 1'b0, 1'b0, "post-reset 0x188 hit");

        check("pending AR expectations", 32'(ar_exp_q.size()), 32'd0);
        check("pending responses", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
